// File: rtl/wdrc_pkg.sv
// Shared WDRC definitions: datapath widths and envelope follower state encoding.
package wdrc_pkg;

    localparam int unsigned WDRC_DATA_W = 24;
    localparam int unsigned WDRC_COEF_W = 8;
    localparam int unsigned WDRC_HOLD_W = 12;

    typedef enum logic [1:0] {
        ENV_ATTACK  = 2'b00,
        ENV_HOLD    = 2'b01,
        ENV_RELEASE = 2'b10
    } env_state_e;

endpackage

// File: rtl/wdrc_envelope_detector_if.sv
// Audio-in / envelope-out bundle between band filter, envelope detector and compressor.
interface wdrc_envelope_detector_if
    import wdrc_pkg::*;
#(
    parameter int unsigned DATA_W = WDRC_DATA_W
);

    logic              in_valid;
    logic [DATA_W-1:0] audio_in;
    logic [DATA_W-1:0] env_out;
    logic              env_valid;
    env_state_e        env_state;

    modport master (
        output in_valid,
        output audio_in,
        input  env_out,
        input  env_valid,
        input  env_state
    );

    modport slave (
        input  in_valid,
        input  audio_in,
        output env_out,
        output env_valid,
        output env_state
    );

endinterface

// File: rtl/wdrc_rectify.sv
// Full-wave rectifier: magnitude of a two's complement sample, most-negative code
// saturated to the largest positive magnitude so the result always fits DATA_W-1 bits.
module wdrc_rectify
    import wdrc_pkg::*;
#(
    parameter int unsigned DATA_W = WDRC_DATA_W
) (
    input  logic [DATA_W-1:0] sample_i,
    output logic [DATA_W-1:0] mag_o
);

    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

    // Absolute value with saturation of the single unrepresentable magnitude.
    always_comb begin
        mag_o = sample_i;
        if (sample_i == MOST_NEG) begin
            mag_o = MOST_POS;
        end else if (sample_i[DATA_W-1]) begin
            mag_o = (~sample_i) + DATA_W'(1);
        end
    end

endmodule

// File: rtl/wdrc_envelope_detector.sv
// Per-band envelope follower: rectified audio smoothed by attack/hold/release one-pole
// filtering, with an optionally decimated output strobe for the compressor band.
module wdrc_envelope_detector
    import wdrc_pkg::*;
#(
    parameter int unsigned DATA_W = WDRC_DATA_W,
    parameter int unsigned COEF_W = WDRC_COEF_W,
    parameter int unsigned HOLD_W = WDRC_HOLD_W,
    parameter int unsigned DECIM  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [COEF_W-1:0]        attack_coef,
    input  logic [COEF_W-1:0]        release_coef,
    input  logic [HOLD_W-1:0]        hold_samples,
    wdrc_envelope_detector_if.slave  bus
);

    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam int unsigned DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic              accept;
    logic [DATA_W-1:0] rect;
    logic              rising;
    logic [DATA_W-1:0] diff;
    logic [COEF_W-1:0] coef;
    logic [PROD_W-1:0] prod;
    logic [DATA_W-1:0] step;

    env_state_e        state_q, state_d;
    logic [DATA_W-1:0] env_q, env_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [DCNT_W-1:0] decim_q, decim_d;
    logic              valid_q, valid_d;

    assign accept = bus.in_valid && enable;

    wdrc_rectify #(
        .DATA_W(DATA_W)
    ) u_rectify (
        .sample_i(bus.audio_in),
        .mag_o   (rect)
    );

    // Smoothing step toward the rectified sample; coef < 2^COEF_W keeps step <= diff,
    // so the envelope can never overshoot the target or wrap.
    always_comb begin
        rising = (rect >= env_q);
        diff   = rising ? (rect - env_q) : (env_q - rect);
        coef   = rising ? attack_coef : release_coef;
        prod   = PROD_W'(diff) * PROD_W'(coef);
        step   = DATA_W'(prod >> COEF_W);
        if ((coef != '0) && (diff != '0) && (step == '0)) begin
            step = DATA_W'(1);
        end
    end

    // Attack/hold/release decision and decimation count, evaluated per accepted sample.
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        hold_d  = hold_q;
        decim_d = decim_q;
        valid_d = 1'b0;
        if (accept) begin
            if (rising) begin
                state_d = ENV_ATTACK;
                env_d   = env_q + step;
                hold_d  = hold_samples;
            end else if (hold_q != '0) begin
                state_d = ENV_HOLD;
                hold_d  = hold_q - HOLD_W'(1);
            end else begin
                state_d = ENV_RELEASE;
                env_d   = env_q - step;
            end
            if (decim_q == DCNT_W'(DECIM - 1)) begin
                decim_d = '0;
                valid_d = 1'b1;
            end else begin
                decim_d = decim_q + DCNT_W'(1);
            end
        end
    end

    // State, envelope and strobe registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ENV_RELEASE;
            env_q   <= '0;
            hold_q  <= '0;
            decim_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            hold_q  <= hold_d;
            decim_q <= decim_d;
            valid_q <= valid_d;
        end
    end

    assign bus.env_out   = env_q;
    assign bus.env_valid = valid_q;
    assign bus.env_state = state_q;

endmodule

// File: tb/tb_wdrc_envelope_detector.sv
// Self-checking bench for wdrc_envelope_detector: directed table, hand-written corner
// sequences, and randomized stimulus against an arithmetic reference model.
module tb_wdrc_envelope_detector;
    import wdrc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [7:0]  attack_coef;
    logic [7:0]  release_coef;
    logic [11:0] hold_samples;

    wdrc_envelope_detector_if #(.DATA_W(24)) bus1 ();
    wdrc_envelope_detector_if #(.DATA_W(24)) bus4 ();

    always #5 clk = ~clk;

    wdrc_envelope_detector #(
        .DATA_W(24), .COEF_W(8), .HOLD_W(12), .DECIM(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .attack_coef(attack_coef), .release_coef(release_coef),
        .hold_samples(hold_samples), .bus(bus1)
    );

    wdrc_envelope_detector #(
        .DATA_W(24), .COEF_W(8), .HOLD_W(12), .DECIM(4)
    ) dut4 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .attack_coef(attack_coef), .release_coef(release_coef),
        .hold_samples(hold_samples), .bus(bus4)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    longint m_env;
    int     m_hold;
    int     m_state;
    int     m_acc;
    bit     m_valid1;
    bit     m_valid4;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint rect_of(input logic [23:0] a);
        longint v;
        v = longint'($signed(a));
        if (v < 0) v = -v;
        if (v > 64'd8388607) v = 64'd8388607;
        return v;
    endfunction

    function automatic longint step_of(input longint d, input int c);
        longint s;
        s = (d * c) / 256;
        if (c != 0 && d != 0 && s == 0) s = 1;
        return s;
    endfunction

    task automatic model_reset();
        m_env = 0; m_hold = 0; m_state = 2; m_acc = 0; m_valid1 = 0; m_valid4 = 0;
    endtask

    task automatic model_sample(input bit en, input bit vld, input logic [23:0] audio,
                                input int a, input int r, input int h);
        longint rr;
        m_valid1 = 0;
        m_valid4 = 0;
        if (en && vld) begin
            rr = rect_of(audio);
            if (rr >= m_env) begin
                m_env += step_of(rr - m_env, a);
                m_hold = h;
                m_state = 0;
            end else if (m_hold > 0) begin
                m_hold--;
                m_state = 1;
            end else begin
                m_env -= step_of(m_env - rr, r);
                m_state = 2;
            end
            m_acc++;
            m_valid1 = 1;
            m_valid4 = (m_acc % 4 == 0);
        end
    endtask

    task automatic cyc(input bit en, input bit vld, input logic [23:0] audio,
                       input int a, input int r, input int h);
        @(negedge clk);
        enable        = en;
        bus1.in_valid = vld;
        bus4.in_valid = vld;
        bus1.audio_in = audio;
        bus4.audio_in = audio;
        attack_coef   = 8'(a);
        release_coef  = 8'(r);
        hold_samples  = 12'(h);
        @(posedge clk);
        #1;
        model_sample(en, vld, audio, a, r, h);
    endtask

    task automatic do_reset();
        @(negedge clk);
        enable = 1'b0;
        bus1.in_valid = 1'b0;
        bus4.in_valid = 1'b0;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit          rst;
        bit          en;
        bit          vld;
        logic [23:0] audio;
        int          a;
        int          r;
        int          h;
        logic [23:0] e_env;
        bit          e_valid;
        logic [1:0]  e_state;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t V(input bit rst, input bit en, input bit vld,
                               input logic [23:0] audio, input int a, input int r, input int h,
                               input logic [23:0] e_env, input bit e_valid, input logic [1:0] e_state);
        vec_t v;
        v.rst = rst; v.en = en; v.vld = vld; v.audio = audio;
        v.a = a; v.r = r; v.h = h;
        v.e_env = e_env; v.e_valid = e_valid; v.e_state = e_state;
        return v;
    endfunction

    initial begin
        logic [23:0] mag;
        logic [23:0] aud;
        rst_n = 1'b0;
        enable = 1'b0;
        bus1.in_valid = 1'b0; bus4.in_valid = 1'b0;
        bus1.audio_in = '0;   bus4.audio_in = '0;
        attack_coef = '0; release_coef = '0; hold_samples = '0;
        model_reset();

        // reset, steady attack toward 0x100000 at half-error per sample
        tbl.push_back(V(1, 0, 0, 24'h0, 0, 0, 0, 24'h000000, 0, 2'b10));
        tbl.push_back(V(0, 1, 1, 24'h100000, 128, 0, 0, 24'h080000, 1, 2'b00));
        tbl.push_back(V(0, 1, 1, 24'h100000, 128, 0, 0, 24'h0C0000, 1, 2'b00));
        tbl.push_back(V(0, 1, 1, 24'h100000, 128, 0, 0, 24'h0E0000, 1, 2'b00));
        tbl.push_back(V(0, 1, 0, 24'h100000, 128, 0, 0, 24'h0E0000, 0, 2'b00));
        // most-negative input saturates; 0x7FFFFF*255>>8 = 0x7F7FFF
        tbl.push_back(V(1, 0, 0, 24'h0, 0, 0, 0, 24'h000000, 0, 2'b10));
        tbl.push_back(V(0, 1, 1, 24'h800000, 255, 0, 0, 24'h7F7FFF, 1, 2'b00));
        // negative sample rectifies
        tbl.push_back(V(1, 0, 0, 24'h0, 0, 0, 0, 24'h000000, 0, 2'b10));
        tbl.push_back(V(0, 1, 1, 24'hF00000, 128, 0, 0, 24'h080000, 1, 2'b00));
        // climb to 0x400000, then hold 3 samples, then release at 1/4
        tbl.push_back(V(1, 0, 0, 24'h0, 0, 0, 0, 24'h000000, 0, 2'b10));
        tbl.push_back(V(0, 1, 1, 24'h400000, 255, 64, 3, 24'h3FC000, 1, 2'b00));
        tbl.push_back(V(0, 1, 1, 24'h400000, 255, 64, 3, 24'h3FFFC0, 1, 2'b00));
        tbl.push_back(V(0, 1, 1, 24'h400000, 255, 64, 3, 24'h3FFFFF, 1, 2'b00));
        tbl.push_back(V(0, 1, 1, 24'h400000, 255, 64, 3, 24'h400000, 1, 2'b00));
        tbl.push_back(V(0, 1, 1, 24'h000000, 255, 64, 3, 24'h400000, 1, 2'b01));
        tbl.push_back(V(0, 1, 1, 24'h000000, 255, 64, 3, 24'h400000, 1, 2'b01));
        tbl.push_back(V(0, 1, 1, 24'h000000, 255, 64, 3, 24'h400000, 1, 2'b01));
        tbl.push_back(V(0, 1, 1, 24'h000000, 255, 64, 3, 24'h300000, 1, 2'b10));
        tbl.push_back(V(0, 1, 1, 24'h000000, 255, 64, 3, 24'h240000, 1, 2'b10));
        // min-step with attack=1
        tbl.push_back(V(1, 0, 0, 24'h0, 0, 0, 0, 24'h000000, 0, 2'b10));
        tbl.push_back(V(0, 1, 1, 24'h000010, 255, 0, 0, 24'h00000F, 1, 2'b00));
        tbl.push_back(V(0, 1, 1, 24'h000010, 255, 0, 0, 24'h000010, 1, 2'b00));
        tbl.push_back(V(0, 1, 1, 24'h000011, 1, 0, 0, 24'h000011, 1, 2'b00));
        // attack=0 freezes; enable low ignores; release=0 freezes; release=128 halves
        tbl.push_back(V(1, 0, 0, 24'h0, 0, 0, 0, 24'h000000, 0, 2'b10));
        tbl.push_back(V(0, 1, 1, 24'h000010, 255, 0, 0, 24'h00000F, 1, 2'b00));
        tbl.push_back(V(0, 1, 1, 24'h000010, 255, 0, 0, 24'h000010, 1, 2'b00));
        tbl.push_back(V(0, 1, 1, 24'h000011, 0, 0, 0, 24'h000010, 1, 2'b00));
        tbl.push_back(V(0, 0, 1, 24'h7FFFFF, 255, 255, 0, 24'h000010, 0, 2'b00));
        tbl.push_back(V(0, 1, 1, 24'h000000, 0, 0, 0, 24'h000010, 1, 2'b10));
        tbl.push_back(V(0, 1, 1, 24'h000000, 0, 128, 0, 24'h000008, 1, 2'b10));
        // hold_samples change during HOLD has no effect until next attack reload
        tbl.push_back(V(1, 0, 0, 24'h0, 0, 0, 0, 24'h000000, 0, 2'b10));
        tbl.push_back(V(0, 1, 1, 24'h000100, 255, 0, 2, 24'h0000FF, 1, 2'b00));
        tbl.push_back(V(0, 1, 1, 24'h000100, 255, 0, 2, 24'h000100, 1, 2'b00));
        tbl.push_back(V(0, 1, 1, 24'h000000, 255, 128, 9, 24'h000100, 1, 2'b01));
        tbl.push_back(V(0, 1, 1, 24'h000000, 255, 128, 9, 24'h000100, 1, 2'b01));
        tbl.push_back(V(0, 1, 1, 24'h000000, 255, 128, 9, 24'h000080, 1, 2'b10));

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            else cyc(tbl[i].en, tbl[i].vld, tbl[i].audio, tbl[i].a, tbl[i].r, tbl[i].h);
            chk($sformatf("tbl%0d_env", i),   bus1.env_out,   tbl[i].e_env);
            chk($sformatf("tbl%0d_valid", i), bus1.env_valid, tbl[i].e_valid);
            chk($sformatf("tbl%0d_state", i), bus1.env_state, tbl[i].e_state);
        end

        // asynchronous reset in the middle of HOLD drops the pending strobe at once
        do_reset();
        repeat (4) cyc(1, 1, 24'h400000, 255, 64, 100);
        cyc(1, 1, 24'h000000, 255, 64, 100);
        cyc(1, 1, 24'h000000, 255, 64, 100);
        chk("hold_pre_state", bus1.env_state, 1);
        chk("hold_pre_valid", bus1.env_valid, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_env",   bus1.env_out, 0);
        chk("arst_state", bus1.env_state, 2);
        chk("arst_valid", bus1.env_valid, 0);
        chk("arst_valid4", bus4.env_valid, 0);
        model_reset();
        #1;
        rst_n = 1'b1;

        // DECIM=4: strobe only after accepted samples 4 and 8; idle cycles not counted
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                cyc(1, 0, 24'h123456, 100, 100, 0);
                chk("dec_idle_valid", bus4.env_valid, 0);
            end
            cyc(1, 1, 24'($urandom), 100, 50, 1);
            chk($sformatf("dec%0d_valid", i), bus4.env_valid, ((i + 1) % 4 == 0) ? 1 : 0);
            chk($sformatf("dec%0d_env", i), bus4.env_out, m_env);
            chk($sformatf("dec%0d_env1", i), bus1.env_out, m_env);
        end

        // randomized stimulus against the reference model
        do_reset();
        for (int n = 0; n < 500; n++) begin
            int sel;
            int a;
            int r;
            sel = $urandom_range(0, 19);
            if (sel == 0) aud = 24'h800000;
            else if (sel == 1) aud = 24'h000000;
            else begin
                mag = 24'($urandom) >> $urandom_range(0, 22);
                mag[23] = 1'b0;
                aud = $urandom_range(0, 1) ? (~mag + 24'd1) : mag;
            end
            a = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, 255);
            r = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 255);
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, aud, a, r,
                $urandom_range(0, 6));
            chk("rnd_env",    bus1.env_out,   m_env);
            chk("rnd_state",  bus1.env_state, m_state);
            chk("rnd_valid",  bus1.env_valid, m_valid1);
            chk("rnd_env4",   bus4.env_out,   m_env);
            chk("rnd_valid4", bus4.env_valid, m_valid4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
